// File: rtl/ula_sequenciador.sv
// Accumulator command sequencer driving an external combinational 32-bit ALU:
// applies acc = acc OP operand for count+1 cycles and returns the result.
module ula_sequenciador #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_operand,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_clear,
    input  logic             cmd_cin,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_cin,
    output logic             alu_bin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             alu_bout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_borrow,
    output logic             rsp_zero,
    output logic             busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_operand;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_remaining;
    logic             r_cin;
    logic             r_first;
    logic             r_carry;
    logic             r_borrow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = cmd_clear ? ST_CLR : ST_EXEC;
                end
            end
            ST_CLR:  w_next = ST_EXEC;
            ST_EXEC: begin
                if (r_remaining == '0) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Command latch, accumulator update and iteration counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_operand   <= '0;
            r_op        <= 3'b000;
            r_remaining <= '0;
            r_cin       <= 1'b0;
            r_first     <= 1'b0;
            r_carry     <= 1'b0;
            r_borrow    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op        <= cmd_op;
                        r_operand   <= cmd_operand;
                        r_remaining <= cmd_count;
                        r_cin       <= cmd_cin;
                        r_first     <= ~cmd_clear;
                    end
                end
                ST_CLR: begin
                    r_acc   <= '0;
                    r_first <= 1'b1;
                end
                ST_EXEC: begin
                    r_acc    <= alu_result;
                    r_carry  <= alu_cout;
                    r_borrow <= alu_bout;
                    r_first  <= 1'b0;
                    if (r_remaining != '0) begin
                        r_remaining <= r_remaining - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Carry/borrow-in only reach the ALU on the first iteration of add/sub
    assign alu_a      = r_acc;
    assign alu_b      = r_operand;
    assign alu_op     = r_op;
    assign alu_cin    = r_cin & r_first & (r_op == OP_ADD);
    assign alu_bin    = r_cin & r_first & (r_op == OP_SUB);

    assign cmd_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign rsp_valid  = (r_state == ST_RESP);
    assign rsp_data   = r_acc;
    assign rsp_carry  = r_carry;
    assign rsp_borrow = r_borrow;
    assign rsp_zero   = (r_acc == '0);

endmodule

// File: tb/tb_ula_sequenciador.sv
// Directed bench for ula_sequenciador with a behavioural ula_32bits model.
module tb_ula_sequenciador;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_operand;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_clear;
    logic             cmd_cin;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic             alu_cin;
    logic             alu_bin;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;
    logic             alu_bout;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_carry;
    logic             rsp_borrow;
    logic             rsp_zero;
    logic             busy;

    int n_cmp;
    int n_err;
    int cin_hi_cnt;
    int rsp_hi_cnt;

    ula_sequenciador #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_operand(cmd_operand), .cmd_count(cmd_count),
        .cmd_clear(cmd_clear), .cmd_cin(cmd_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_cin(alu_cin), .alu_bin(alu_bin),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_bout(alu_bout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_borrow(rsp_borrow),
        .rsp_zero(rsp_zero), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the external combinational ALU
    logic [WIDTH:0] alu_ext;
    always_comb begin
        alu_ext    = '0;
        alu_result = '0;
        alu_cout   = 1'b0;
        alu_bout   = 1'b0;
        case (alu_op)
            3'b000: begin
                alu_ext    = {1'b0, alu_a} + {1'b0, alu_b} + (WIDTH+1)'(alu_cin);
                alu_result = alu_ext[WIDTH-1:0];
                alu_cout   = alu_ext[WIDTH];
            end
            3'b001: begin
                alu_ext    = {1'b0, alu_a} - {1'b0, alu_b} - (WIDTH+1)'(alu_bin);
                alu_result = alu_ext[WIDTH-1:0];
                alu_bout   = alu_ext[WIDTH];
            end
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = ~(alu_a & alu_b);
            3'b101:  alu_result = ~(alu_a ^ alu_b);
            3'b110:  alu_result = ~alu_a;
            default: alu_result = alu_a;
        endcase
    end

    always @(posedge clk) begin
        if (alu_cin)   cin_hi_cnt <= cin_hi_cnt + 1;
        if (rsp_valid) rsp_hi_cnt <= rsp_hi_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command and wait (bounded) for rsp_valid; lat = edges after accept
    task automatic run_cmd(input logic [2:0] op, input logic [31:0] opnd,
                           input logic [7:0] cnt, input logic clr, input logic ci,
                           output int lat);
        @(negedge clk);
        chk("cmd_ready_before_accept", cmd_ready, 1'b1);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_operand = opnd;
        cmd_count   = cnt;
        cmd_clear   = clr;
        cmd_cin     = ci;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_cin   = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("rsp_valid_arrived", rsp_valid, 1'b1);
    endtask

    task automatic ack_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("idle_after_ack", cmd_ready, 1'b1);
        chk("busy_after_ack", busy, 1'b0);
    endtask

    initial begin
        int lat;
        int snap;
        n_cmp = 0; n_err = 0; cin_hi_cnt = 0; rsp_hi_cnt = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_operand = '0;
        cmd_count = '0; cmd_clear = 1'b0; cmd_cin = 1'b0; rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_zero", rsp_zero, 1'b1);
        chk("rst_rsp_flags", {rsp_carry, rsp_borrow}, 2'b00);
        chk("rst_alu_ab", {alu_a, alu_b}, 64'h0);
        chk("rst_alu_op_cin_bin", {alu_op, alu_cin, alu_bin}, 5'b0);
        rst_n = 1'b1;

        // Repeated add: 4 x 5 from cleared acc
        run_cmd(3'b000, 32'd5, 8'd3, 1'b1, 1'b0, lat);
        chk("add4x5_latency", 64'(lat), 64'd5);
        chk("add4x5_data", rsp_data, 32'd20);
        chk("add4x5_carry_zero", {rsp_carry, rsp_zero}, 2'b00);
        ack_rsp();

        // Load all-ones, then add 1 wraps to zero with carry
        run_cmd(3'b011, 32'hFFFF_FFFF, 8'd0, 1'b1, 1'b0, lat);
        chk("load_latency", 64'(lat), 64'd2);
        chk("load_ones", rsp_data, 32'hFFFF_FFFF);
        ack_rsp();
        run_cmd(3'b000, 32'd1, 8'd0, 1'b0, 1'b0, lat);
        chk("ovf_latency", 64'(lat), 64'd1);
        chk("ovf_data", rsp_data, 32'h0);
        chk("ovf_carry_zero", {rsp_carry, rsp_zero}, 2'b11);
        ack_rsp();

        // Sub underflow 3 - 5
        run_cmd(3'b011, 32'd3, 8'd0, 1'b1, 1'b0, lat);
        ack_rsp();
        run_cmd(3'b001, 32'd5, 8'd0, 1'b0, 1'b0, lat);
        chk("sub_uf_data", rsp_data, 32'hFFFF_FFFE);
        chk("sub_uf_borrow_carry", {rsp_borrow, rsp_carry}, 2'b10);
        ack_rsp();

        // Carry-in applies to the first iteration only
        snap = cin_hi_cnt;
        run_cmd(3'b000, 32'd7, 8'd1, 1'b1, 1'b1, lat);
        chk("cin_first_data", rsp_data, 32'd15);
        chk("cin_high_cycles", 64'(cin_hi_cnt - snap), 64'd1);
        ack_rsp();

        // Accumulator persists through a chain of logic ops
        run_cmd(3'b011, 32'h0000_00F0, 8'd0, 1'b0, 1'b0, lat);
        chk("or_persist", rsp_data, 32'h0000_00FF);
        ack_rsp();
        run_cmd(3'b110, 32'h0, 8'd0, 1'b0, 1'b0, lat);
        chk("not_acc", rsp_data, 32'hFFFF_FF00);
        ack_rsp();
        run_cmd(3'b100, 32'hFFFF_0000, 8'd0, 1'b0, 1'b0, lat);
        chk("nand", rsp_data, 32'h0000_FFFF);
        ack_rsp();
        run_cmd(3'b101, 32'h0000_FFFF, 8'd0, 1'b0, 1'b0, lat);
        chk("xnor", rsp_data, 32'hFFFF_FFFF);
        ack_rsp();
        run_cmd(3'b111, 32'h1234_0000, 8'd2, 1'b0, 1'b0, lat);
        chk("pass", rsp_data, 32'hFFFF_FFFF);
        ack_rsp();
        run_cmd(3'b010, 32'h1234_5678, 8'd0, 1'b0, 1'b0, lat);
        chk("and", rsp_data, 32'h1234_5678);
        ack_rsp();

        // Borrow-in with repeated sub: 10 - 3 - 1, then -3 twice
        run_cmd(3'b011, 32'd10, 8'd0, 1'b1, 1'b0, lat);
        ack_rsp();
        run_cmd(3'b001, 32'd3, 8'd2, 1'b0, 1'b1, lat);
        chk("sub_bin_data", rsp_data, 32'd0);
        chk("sub_bin_flags", {rsp_borrow, rsp_zero}, 2'b01);
        ack_rsp();

        // Maximum count: 256 iterations of +1
        run_cmd(3'b000, 32'd1, 8'd255, 1'b1, 1'b0, lat);
        chk("max_cnt_latency", 64'(lat), 64'd257);
        chk("max_cnt_data", rsp_data, 32'd256);
        ack_rsp();

        // Backpressure: response held while commands are offered and refused
        run_cmd(3'b000, 32'd9, 8'd0, 1'b1, 1'b0, lat);
        cmd_op = 3'b011; cmd_operand = 32'hFFFF; cmd_clear = 1'b1; cmd_count = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmd_valid = i[0];
            chk("bp_cmd_ready", cmd_ready, 1'b0);
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_data", rsp_data, 32'd9);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        ack_rsp();
        chk("bp_acc_kept", alu_a, 32'd9);

        // Reset mid-EXEC after 10 iterations of +1
        snap = rsp_hi_cnt;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'b000; cmd_operand = 32'd1;
        cmd_count = 8'd200; cmd_clear = 1'b1; cmd_cin = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("pre_reset_acc", alu_a, 32'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_acc", alu_a, 32'd0);
        chk("rst_mid_ready_busy", {cmd_ready, busy}, 2'b10);
        chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_mid_no_rsp", 64'(rsp_hi_cnt - snap), 64'd0);

        // Accumulator restarts from zero after reset
        run_cmd(3'b000, 32'd4, 8'd0, 1'b0, 1'b0, lat);
        chk("post_rst_data", rsp_data, 32'd4);
        ack_rsp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
